hsi_s_tx_framer: RTL

- Parametrised next-generation slave-side HSI transmit controller, driven by the RX frame decoder.
- On a response request it selects one of NUM_SRC byte sources (status, data packets, ...) and streams that source's bytes to the line coder with a busy handshake.
- Appends a big-endian CRC16-CCITT trailer and reports done/abort/truncation.
- Sits between the RX flag decoder, the source controllers and the coder; the dat1/dat2 drive stays outside it.

---
 rtl/hsi_tx_pkg.sv | 33 +++
 rtl/crc16_ccitt_byte.sv | 25 ++
 rtl/hsi_s_tx_framer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/hsi_tx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | hsi_tx_pkg : shared types and CRC constants for the HSI slave TX framer |
// | Revision   : 1.0  initial release  (optional macro HSI_TX_PREAMBLE_EN)  |
// +------------------------------------------------------------------------+
package hsi_tx_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_SEED = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CRC_HI = 3'd4,
    ST_CRC_LO = 3'd5,
    ST_DONE   = 3'd6
`ifdef HSI_TX_PREAMBLE_EN
   ,ST_PRE    = 3'd7
`endif
  } state_t;

  // Tells WAIT which byte kind was just strobed, so it knows where to go next.
  typedef enum logic [1:0] {
    PH_DATA   = 2'd0,
    PH_CRC_HI = 2'd1,
    PH_CRC_LO = 2'd2,
    PH_PRE    = 2'd3
  } phase_t;

endpackage
`default_nettype wire

// File: rtl/crc16_ccitt_byte.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | crc16_ccitt_byte : combinational CRC16-CCITT update, one byte MSB-first |
// | Revision         : 1.0  initial release                                 |
// +------------------------------------------------------------------------+
module crc16_ccitt_byte
  import hsi_tx_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] w_c;

  always_comb begin
    w_c = i_crc ^ {i_data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[15] ? ((w_c << 1) ^ CRC16_POLY) : (w_c << 1);
    end
    o_crc = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/hsi_s_tx_framer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | hsi_s_tx_framer : slave HSI TX framer, source mux + CRC16 trailer       |
// | Revision        : 1.0  initial release  (optional macro HSI_TX_PREAMBLE_EN) |
// +------------------------------------------------------------------------+
module hsi_s_tx_framer
  import hsi_tx_pkg::*;
#(
  parameter  int          NUM_SRC       = 2,
  parameter  int          MAX_LEN       = 256,
  parameter  int          CRC_BYTES     = 2,
  parameter  logic [15:0] CRC_INIT      = CRC16_SEED,
  parameter  logic [7:0]  PREAMBLE_BYTE = 8'h7E,
  localparam int          SRC_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int          LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clk_en,
  input  logic                 req_valid,
  input  logic [SRC_W-1:0]     req_src,
  output logic                 req_ack,
  input  logic                 rx_err,
  input  logic [NUM_SRC*8-1:0] src_d,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           cd_d,
  output logic                 cd_d_rdy,
  input  logic                 cd_busy,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 truncated
);

  state_t               r_state;
  phase_t               r_phase;
  logic [SRC_W-1:0]     r_sel;
  logic [7:0]           r_byte;
  logic                 r_last;
  logic [LEN_W-1:0]     r_count;
  logic [15:0]          r_crc;
  logic                 r_guard;
  logic [7:0]           r_cd_d;
  logic                 r_req_ack;
  logic [NUM_SRC-1:0]   r_src_ready;
  logic                 r_cd_d_rdy;
  logic                 r_done;
  logic                 r_abort;
  logic                 r_trunc;

  logic [7:0]           w_src_byte;
  logic                 w_src_valid;
  logic                 w_src_last;
  logic [NUM_SRC-1:0]   w_sel_onehot;
  logic                 w_req_ok;
  logic                 w_at_max;
  logic [15:0]          w_crc_next;

  always_comb begin
    w_src_byte   = 8'h00;
    w_src_valid  = 1'b0;
    w_src_last   = 1'b0;
    w_sel_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (32'(r_sel) == i) begin
        w_src_byte      = src_d[i*8 +: 8];
        w_src_valid     = src_valid[i];
        w_src_last      = src_last[i];
        w_sel_onehot[i] = 1'b1;
      end
    end
  end

  assign w_req_ok = (32'(req_src) < NUM_SRC);
  assign w_at_max = (r_count == LEN_W'(MAX_LEN - 1));

  crc16_ccitt_byte u_crc (
    .i_crc  (r_crc),
    .i_data (r_byte),
    .o_crc  (w_crc_next)
  );

  // Pulses are held across disabled cycles and shown only on the next enabled one.
  assign req_ack     = r_req_ack  & clk_en;
  assign src_ready   = r_src_ready & {NUM_SRC{clk_en}};
  assign cd_d_rdy    = r_cd_d_rdy & clk_en;
  assign frame_done  = r_done     & clk_en;
  assign frame_abort = r_abort    & clk_en;
  assign cd_d        = r_cd_d;
  assign truncated   = r_trunc;
  assign busy        = (r_state != ST_IDLE);

`ifndef HSI_TX_PREAMBLE_EN
  logic w_unused_pre;
  assign w_unused_pre = ^PREAMBLE_BYTE;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= PH_DATA;
      r_sel       <= '0;
      r_byte      <= 8'h00;
      r_last      <= 1'b0;
      r_count     <= '0;
      r_crc       <= CRC_INIT;
      r_guard     <= 1'b0;
      r_cd_d      <= 8'h00;
      r_req_ack   <= 1'b0;
      r_src_ready <= '0;
      r_cd_d_rdy  <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_trunc     <= 1'b0;
    end else if (clk_en) begin
      r_req_ack   <= 1'b0;
      r_src_ready <= '0;
      r_cd_d_rdy  <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      if ((r_state != ST_IDLE) && rx_err) begin
        r_state <= ST_IDLE;
        r_abort <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (req_valid && w_req_ok) begin
              r_sel     <= req_src;
              r_req_ack <= 1'b1;
              r_crc     <= CRC_INIT;
              r_count   <= '0;
              r_trunc   <= 1'b0;
`ifdef HSI_TX_PREAMBLE_EN
              r_state   <= ST_PRE;
`else
              r_state   <= ST_FETCH;
`endif
            end
          end
          ST_FETCH: begin
            if (w_src_valid) begin
              r_byte      <= w_src_byte;
              r_last      <= w_src_last | w_at_max;
              r_src_ready <= w_sel_onehot;
              if (w_at_max && !w_src_last) r_trunc <= 1'b1;
              r_state     <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (!cd_busy) begin
              r_cd_d     <= r_byte;
              r_cd_d_rdy <= 1'b1;
              r_crc      <= w_crc_next;
              r_count    <= r_count + LEN_W'(1);
              r_phase    <= PH_DATA;
              r_guard    <= 1'b1;
              r_state    <= ST_WAIT;
            end
          end
          // The coder raises cd_busy one cycle after a strobe; skip that cycle.
          ST_WAIT: begin
            if (r_guard) begin
              r_guard <= 1'b0;
            end else if (!cd_busy) begin
              case (r_phase)
                PH_DATA:   r_state <= r_last ? ((CRC_BYTES != 0) ? ST_CRC_HI : ST_DONE) : ST_FETCH;
                PH_PRE:    r_state <= ST_FETCH;
                PH_CRC_HI: r_state <= ST_CRC_LO;
                default:   r_state <= ST_DONE;
              endcase
            end
          end
          ST_CRC_HI: begin
            if (!cd_busy) begin
              r_cd_d     <= r_crc[15:8];
              r_cd_d_rdy <= 1'b1;
              r_phase    <= PH_CRC_HI;
              r_guard    <= 1'b1;
              r_state    <= ST_WAIT;
            end
          end
          ST_CRC_LO: begin
            if (!cd_busy) begin
              r_cd_d     <= r_crc[7:0];
              r_cd_d_rdy <= 1'b1;
              r_phase    <= PH_CRC_LO;
              r_guard    <= 1'b1;
              r_state    <= ST_WAIT;
            end
          end
          ST_DONE: begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
`ifdef HSI_TX_PREAMBLE_EN
          ST_PRE: begin
            if (!cd_busy) begin
              r_cd_d     <= PREAMBLE_BYTE;
              r_cd_d_rdy <= 1'b1;
              r_phase    <= PH_PRE;
              r_guard    <= 1'b1;
              r_state    <= ST_WAIT;
            end
          end
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
